// File: rtl/uart_pkg.sv
// uart_pkg: sender state encoding and default word/FIFO sizes shared by the uart blocks
package uart_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_ACK = 2'd1, WAIT_DONE = 2'd2} state_t;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH = 16;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO; ports sys_clk/sys_rst_n, wr_en/din in, rd_en in, dout/level/full/empty out
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign level = wr_ptr - rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge sys_clk)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_en ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= rd_en ? rd_ptr + 1'b1 : rd_ptr;
    end
endmodule

// File: rtl/uart_loop_fifo.sv
// uart_loop_fifo: queues words on recv_done rising edges and replays them to the transmitter; ports recv_done/recv_data/tx_busy in, send_en/send_data/fifo_level/fifo_full/ack_timeout/ovf_cnt out
module uart_loop_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ACK_TO = 15,
  parameter int CNT_W = 16
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     recv_done,
  input  logic [DATA_W-1:0]        recv_data,
  input  logic                     tx_busy,
  output logic                     send_en,
  output logic [DATA_W-1:0]        send_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     fifo_full,
  output logic                     ack_timeout,
  output logic [CNT_W-1:0]         ovf_cnt
);
  localparam int TW = $clog2(ACK_TO + 1);
  state_t state, state_nx;
  logic d0, d1, push_req, pop, wr_en, empty, ovf, to_hit;
  logic [TW-1:0] timer, timer_nx;
  logic [DATA_W-1:0] head;
  assign push_req = d0 & ~d1;
  // a pop in the same cycle frees the slot, so a push at full is still taken
  assign wr_en = push_req & (~fifo_full | pop);
  assign ovf = push_req & fifo_full & ~pop;
  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .wr_en(wr_en),
    .rd_en(pop),
    .din(recv_data),
    .dout(head),
    .level(fifo_level),
    .full(fifo_full),
    .empty(empty)
  );
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    pop = 1'b0;
    to_hit = 1'b0;
    case (state)
      IDLE:
        if (!empty && !tx_busy) begin
          pop = 1'b1;
          timer_nx = TW'(ACK_TO);
          state_nx = WAIT_ACK;
        end
      WAIT_ACK:
        if (tx_busy) state_nx = WAIT_DONE;
        else if (timer == TW'(1)) begin
          to_hit = 1'b1;
          state_nx = IDLE;
        end else timer_nx = timer - 1'b1;
      WAIT_DONE:
        if (!tx_busy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state <= IDLE;
      timer <= '0;
      d0 <= 1'b0;
      d1 <= 1'b0;
      send_en <= 1'b0;
      send_data <= '0;
      ack_timeout <= 1'b0;
      ovf_cnt <= '0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      d0 <= recv_done;
      d1 <= d0;
      send_en <= pop;
      send_data <= pop ? head : send_data;
      ack_timeout <= to_hit;
      ovf_cnt <= (ovf && !(&ovf_cnt)) ? ovf_cnt + 1'b1 : ovf_cnt;
    end
endmodule

// File: tb/tb_uart_loop_fifo.sv
// tb_uart_loop_fifo: scoreboard bench over three configurations of uart_loop_fifo selected by sel
module tb_uart_loop_fifo;
  logic sys_clk = 1'b0;
  logic rst_n = 1'b0;
  logic recv_done = 1'b0;
  logic tx_busy = 1'b0;
  logic [63:0] recv_data = '0;
  int sel = 0;
  int ntot = 0;
  int npass = 0;
  logic [63:0] exp_q [$];
  logic prev_en = 1'b0;
  logic en0, en1, en2, full0, full1, full2, to0, to1, to2;
  logic [7:0] data0, data1;
  logic [63:0] data2;
  logic [4:0] lvl0;
  logic [2:0] lvl1;
  logic [1:0] lvl2;
  logic [15:0] ovf0, ovf1;
  logic [1:0] ovf2;
  logic en, full, to;
  logic [63:0] data, lvl, ovf;
  always #5 sys_clk = ~sys_clk;
  uart_loop_fifo dut0 (
    .sys_clk(sys_clk), .sys_rst_n(rst_n),
    .recv_done(sel == 0 && recv_done), .recv_data(recv_data[7:0]), .tx_busy(sel == 0 && tx_busy),
    .send_en(en0), .send_data(data0), .fifo_level(lvl0), .fifo_full(full0),
    .ack_timeout(to0), .ovf_cnt(ovf0)
  );
  uart_loop_fifo #(.DEPTH(4)) dut1 (
    .sys_clk(sys_clk), .sys_rst_n(rst_n),
    .recv_done(sel == 1 && recv_done), .recv_data(recv_data[7:0]), .tx_busy(sel == 1 && tx_busy),
    .send_en(en1), .send_data(data1), .fifo_level(lvl1), .fifo_full(full1),
    .ack_timeout(to1), .ovf_cnt(ovf1)
  );
  uart_loop_fifo #(.DATA_W(64), .DEPTH(2), .CNT_W(2)) dut2 (
    .sys_clk(sys_clk), .sys_rst_n(rst_n),
    .recv_done(sel == 2 && recv_done), .recv_data(recv_data), .tx_busy(sel == 2 && tx_busy),
    .send_en(en2), .send_data(data2), .fifo_level(lvl2), .fifo_full(full2),
    .ack_timeout(to2), .ovf_cnt(ovf2)
  );
  assign en   = sel == 0 ? en0 : sel == 1 ? en1 : en2;
  assign full = sel == 0 ? full0 : sel == 1 ? full1 : full2;
  assign to   = sel == 0 ? to0 : sel == 1 ? to1 : to2;
  assign data = sel == 0 ? 64'(data0) : sel == 1 ? 64'(data1) : data2;
  assign lvl  = sel == 0 ? 64'(lvl0) : sel == 1 ? 64'(lvl1) : 64'(lvl2);
  assign ovf  = sel == 0 ? 64'(ovf0) : sel == 1 ? 64'(ovf1) : 64'(ovf2);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // monitor: every send_en pops one expected word
  always @(negedge sys_clk) begin
    if (rst_n && en) begin
      if (exp_q.size() == 0) begin
        ntot++;
        $display("FAIL spurious_send: got send_data %0h with no word expected", data);
      end else chk("send_data", data, exp_q.pop_front());
      if (prev_en) begin
        ntot++;
        $display("FAIL send_en_back_to_back: got two consecutive cycles, expected one");
      end
    end
    prev_en <= rst_n && en;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic push(input logic [63:0] w);
    recv_data = w;
    recv_done = 1'b1;
    cyc(2);
    recv_done = 1'b0;
    cyc(2);
  endtask

  task automatic wait_en(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      cyc(1);
      ok = en;
    end
    chk(name, 64'(ok), 64'd1);
  endtask

  task automatic do_reset(input int s);
    sel = s;
    rst_n = 1'b0;
    recv_done = 1'b0;
    tx_busy = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
  endtask

  initial begin
    int first, pulses, t_to, t_en2;
    cyc(1);
    do_reset(0);
    chk("rst_send_en", 64'(en), 64'd0);
    chk("rst_send_data", data, 64'd0);
    chk("rst_level", lvl, 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_timeout", 64'(to), 64'd0);
    chk("rst_ovf", ovf, 64'd0);

    // single word latency
    recv_data = 64'hA5;
    recv_done = 1'b1;
    exp_q.push_back(64'hA5);
    first = 0;
    pulses = 0;
    for (int k = 1; k <= 25; k++) begin
      cyc(1);
      if (en) begin
        pulses++;
        if (first == 0) first = k;
      end
      if (k == 4) recv_done = 1'b0;
    end
    chk("single_latency", 64'(first), 64'd3);
    chk("single_pulses", 64'(pulses), 64'd1);

    // burst ordering
    do_reset(0);
    tx_busy = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(64'(i));
      push(64'(i));
    end
    chk("burst_level", lvl, 64'd5);
    tx_busy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_en("burst_send_seen");
      tx_busy = 1'b1;
      cyc(10);
      tx_busy = 1'b0;
    end
    cyc(3);
    chk("burst_level_drained", lvl, 64'd0);

    // overflow at DEPTH=4
    do_reset(1);
    tx_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) exp_q.push_back(64'h11 + 64'(i));
      push(64'h11 + 64'(i));
    end
    chk("ovf_full", 64'(full), 64'd1);
    chk("ovf_cnt", ovf, 64'd2);
    chk("ovf_level", lvl, 64'd4);
    recv_data = 64'h17;
    recv_done = 1'b1;
    exp_q.push_back(64'h17);
    cyc(1);
    tx_busy = 1'b0;
    cyc(1);
    recv_done = 1'b0;
    tx_busy = 1'b1;
    chk("pushpop_full_level", lvl, 64'd4);
    chk("pushpop_full_ovf", ovf, 64'd2);
    chk("pushpop_send_en", 64'(en), 64'd1);
    cyc(5);
    tx_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_en("ovf_send_seen");
      tx_busy = 1'b1;
      cyc(5);
      tx_busy = 1'b0;
    end
    cyc(30);
    chk("ovf_level_drained", lvl, 64'd0);
    chk("ovf_queue_empty", 64'(exp_q.size()), 64'd0);

    // acknowledge timeout
    do_reset(0);
    tx_busy = 1'b1;
    exp_q.push_back(64'h21);
    push(64'h21);
    exp_q.push_back(64'h22);
    push(64'h22);
    tx_busy = 1'b0;
    wait_en("to_send_seen");
    t_to = 0;
    t_en2 = 0;
    pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc(1);
      if (to) begin
        pulses++;
        if (t_to == 0) t_to = k;
      end
      if (en && t_en2 == 0) t_en2 = k;
    end
    chk("to_delay", 64'(t_to), 64'd15);
    chk("to_next_send", 64'(t_en2), 64'd16);
    chk("to_pulse_cycles", 64'(pulses), 64'd2);

    // asynchronous reset mid-transfer
    do_reset(0);
    tx_busy = 1'b1;
    exp_q.push_back(64'h31);
    for (int i = 0; i < 4; i++) push(64'h31 + 64'(i));
    tx_busy = 1'b0;
    wait_en("rst_mid_send_seen");
    tx_busy = 1'b1;
    cyc(2);
    chk("rst_mid_level_before", lvl, 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_send_data", data, 64'd0);
    chk("rst_mid_level", lvl, 64'd0);
    chk("rst_mid_send_en", 64'(en), 64'd0);
    #3;
    rst_n = 1'b1;
    tx_busy = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      if (en) pulses++;
    end
    chk("rst_mid_no_send", 64'(pulses), 64'd0);
    exp_q.push_back(64'h35);
    push(64'h35);
    cyc(3);
    chk("rst_mid_new_send", 64'(exp_q.size()), 64'd0);

    // wide words and saturating overflow counter
    do_reset(2);
    tx_busy = 1'b1;
    exp_q.push_back(64'hDEADBEEF_01234567);
    push(64'hDEADBEEF_01234567);
    exp_q.push_back(64'h01234567_89ABCDEF);
    push(64'h01234567_89ABCDEF);
    for (int i = 0; i < 4; i++) push(64'hF0 + 64'(i));
    chk("wide_full", 64'(full), 64'd1);
    chk("wide_ovf_sat4", ovf, 64'd3);
    push(64'hFF);
    chk("wide_ovf_sat5", ovf, 64'd3);
    chk("wide_level", lvl, 64'd2);
    tx_busy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_en("wide_send_seen");
      tx_busy = 1'b1;
      cyc(3);
      tx_busy = 1'b0;
    end
    cyc(5);
    chk("wide_level_drained", lvl, 64'd0);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/uart_loop_fifo.md
Name: uart_loop_fifo

Overview:
- Parametrised UART loopback controller: detects each receive-done strobe, queues received words in an internal FIFO, and replays them to the UART transmitter one at a time.
- Sits between the receive and transmit modules.
- Decouples bursty receive traffic from transmitter availability, with overflow accounting and a transmit-acknowledge timeout.

Parameters:
- DATA_W, 8, width of recv_data / send_data in bits (1..64)
- DEPTH, 16, FIFO entries; power of two, 2..256
- ACK_TO, 15, cycles to wait for tx_busy to rise after a send_en pulse before abandoning the word (>=1)
- CNT_W, 16, width of the overflow counter

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- recv_done  in  1  receive done; level from the receiver, rising edge marks a new word
- recv_data  in  DATA_W  received word; stable while recv_done is high
- tx_busy  in  1  transmitter busy
- send_en  out  1  one-cycle transmit start pulse
- send_data  out  DATA_W  word to transmit; held until the next pop
- fifo_level  out  $clog2(DEPTH)+1  current occupancy
- fifo_full  out  1  occupancy == DEPTH
- ack_timeout  out  1  one-cycle pulse when ACK_TO expires
- ovf_cnt  out  CNT_W  dropped-word count, saturating

Behaviour:
- Reset: one clock; asynchronous active-low reset on sys_rst_n, the only reset. All registers clear asynchronously:
  - send_en=0, send_data=0, fifo_level=0, fifo_full=0, ack_timeout=0, ovf_cnt=0
  - FIFO pointers=0, FSM=IDLE, edge flops=0
  - Reset mid-transfer discards queued words and any in-flight word; no send_en is issued after release until a new push.
- Edge detect:
  - Two registers d0<=recv_done, d1<=d0.
  - push_req = d0 & ~d1, high exactly one cycle per rising edge.
  - recv_data is sampled into the FIFO on the clock edge that ends the push_req cycle.
- FIFO:
  - Synchronous, DEPTH entries, wr_ptr/rd_ptr of $clog2(DEPTH)+1 bits; MSB distinguishes full from empty; pointers wrap naturally.
  - Push when push_req and (not full, or a pop occurs the same cycle). Simultaneous push+pop on full is accepted and level stays DEPTH.
  - push_req while full with no pop: word dropped, ovf_cnt += 1, saturating at 2^CNT_W-1.
  - Push+pop on empty is impossible: a pop requires non-empty at cycle start.
- Sender FSM (IDLE, WAIT_ACK, WAIT_DONE):
  - IDLE: if FIFO non-empty and tx_busy==0, then pop. send_data<=head and send_en<=1 on that edge; load timer=ACK_TO; go to WAIT_ACK. Otherwise stay.
  - WAIT_ACK: send_en=0.
    - tx_busy==1: go to WAIT_DONE.
    - Else, timer==1: ack_timeout=1 for one cycle, go to IDLE. The word is considered lost and is not retried.
    - Else: timer decrements.
  - WAIT_DONE: on tx_busy==0, go to IDLE. The next pop can occur on the following cycle.
- send_en is never high in consecutive cycles. At most one word is outstanding.
- Latency: first send_en is high 3 cycles after the cycle recv_done is first sampled high, given empty FIFO, IDLE and tx_busy=0.
  - Cycle 1: d0=1, push_req.
  - Cycle 2: word in FIFO.
  - Cycle 3: send_en=1.
- send_data holds its value between pops. A recv_done held high produces one push only. recv_done toggling faster than 2 cycles is not required to be captured.

Decomposition:
- Shared package uart_pkg holds:
  - Sender state encoding localparams: IDLE=2'd0, WAIT_ACK=2'd1, WAIT_DONE=2'd2.
  - Default DATA_W/DEPTH constants, reused by the rx/tx blocks.
- One sub-module: sync_fifo (DATA_W, DEPTH parameters; wr_en/rd_en/din/dout/level/full/empty), first-word-fall-through read.
- Edge detect, FSM, timer and counter stay in uart_loop_fifo.

Test Plan:
- Single word, DATA_W=8: recv_done pulse 4 cycles, recv_data=0xA5, tx_busy=0 -> send_en high exactly 3 cycles after recv_done sampled high; send_data=0xA5; one pulse only.
- Burst ordering: 5 words 0x01..0x05 while tx_busy held 1 -> fifo_level=5. Then emulate busy for 10 cycles per send -> send_data sequence 0x01..0x05, one send_en each, level back to 0.
- Overflow, DEPTH=4: 6 pushes with tx_busy=1 -> fifo_full=1, ovf_cnt=2, and after release only the first 4 words are sent. Also push on the same cycle as a pop at full -> accepted, ovf_cnt unchanged.
- Ack timeout, ACK_TO=15: tx_busy never rises after send_en -> ack_timeout pulses 15 cycles after send_en; FSM returns to IDLE; next queued word sent on the next cycle.
- Reset mid-operation: 3 words queued and FSM in WAIT_DONE, assert sys_rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately; after release no send_en until a new recv_done edge.
- Wide mode, DATA_W=64, DEPTH=2: push 0xDEADBEEF_01234567 -> identical send_data; ovf_cnt saturates when CNT_W=2 after 4+ drops (stays 3).
